// File: rtl/vout_test_pattern.sv
`default_nettype none
// ============================================================================
// Module   : vout_test_pattern
// Brief    : Frame-synchronous RGB test pattern generator with 2-cycle strobe
//            alignment (colour bars, gray ramp, checkerboard, solid colour).
// Revision : 1.0 - initial release
// ============================================================================
module vout_test_pattern #(
    parameter int DATA_W    = 8,
    parameter int CHK_SHIFT = 5
) (
    input  logic                  dp_clk,
    input  logic                  rst_n,
    input  logic [11:0]           h_active,
    input  logic [1:0]            mode,
    input  logic [3*DATA_W-1:0]   solid_rgb,
    input  logic                  in_hs,
    input  logic                  in_vs,
    input  logic                  in_de,
    output logic                  out_hs,
    output logic                  out_vs,
    output logic                  out_de,
    output logic [3*DATA_W-1:0]   out_rgb
);

    localparam logic [DATA_W-1:0] c_ones = '1;
    localparam logic [DATA_W-1:0] c_zero = '0;

    // Frame-latched configuration
    logic [1:0]          r_mode_l;
    logic [3*DATA_W-1:0] r_solid_l;
    logic [11:0]         r_bar_w;
    logic [11:0]         r_y_cnt;

    // Stage 1 pipeline
    logic                r_s1_hs;
    logic                r_s1_vs;
    logic                r_s1_de;
    logic [11:0]         r_s1_x;
    logic                r_s1_y_bit;
    logic [2:0]          r_s1_bar;
    logic [11:0]         r_s1_seg;

    logic                w_fs;
    logic [11:0]         w_x_cnt;
    logic                w_y_bit;
    logic [11:0]         w_bar_w;
    logic                w_bar_end;
    logic [11:0]         w_seg_nxt;
    logic [2:0]          w_bar_nxt;
    logic [2:0]          w_bar_on;
    logic [DATA_W-1:0]   w_ramp;
    logic [3*DATA_W-1:0] w_rgb;

    // Stage 1 registers double as the one-cycle-delayed copies of vs/de.
    assign w_fs      = in_vs & ~r_s1_vs;
    assign w_x_cnt   = (in_de && r_s1_de) ? r_s1_x + 12'd1 : 12'd0;
    assign w_y_bit   = ~w_fs & r_y_cnt[CHK_SHIFT];
    assign w_bar_w   = w_fs ? (h_active >> 3) : r_bar_w;
    assign w_bar_end = (w_bar_w != 12'd0) && (r_s1_seg == w_bar_w - 12'd1);

    always_comb begin
        w_seg_nxt = 12'd0;
        w_bar_nxt = 3'd0;
        if (in_de && r_s1_de) begin
            if (w_bar_end) begin
                w_seg_nxt = 12'd0;
                w_bar_nxt = (r_s1_bar == 3'd7) ? 3'd7 : r_s1_bar + 3'd1;
            end else begin
                w_seg_nxt = r_s1_seg + 12'd1;
                w_bar_nxt = r_s1_bar;
            end
        end
    end

    always_ff @(posedge dp_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode_l  <= 2'd0;
            r_solid_l <= '0;
            r_bar_w   <= 12'd0;
            r_y_cnt   <= 12'd0;
        end else begin
            if (w_fs) begin
                r_mode_l  <= mode;
                r_solid_l <= solid_rgb;
                r_bar_w   <= h_active >> 3;
                r_y_cnt   <= 12'd0;
            end else if (!in_de && r_s1_de) begin
                r_y_cnt   <= r_y_cnt + 12'd1;
            end
        end
    end

    always_ff @(posedge dp_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_hs    <= 1'b0;
            r_s1_vs    <= 1'b0;
            r_s1_de    <= 1'b0;
            r_s1_x     <= 12'd0;
            r_s1_y_bit <= 1'b0;
            r_s1_bar   <= 3'd0;
            r_s1_seg   <= 12'd0;
        end else begin
            r_s1_hs    <= in_hs;
            r_s1_vs    <= in_vs;
            r_s1_de    <= in_de;
            r_s1_x     <= w_x_cnt;
            r_s1_y_bit <= w_y_bit;
            r_s1_bar   <= w_bar_nxt;
            r_s1_seg   <= w_seg_nxt;
        end
    end

    // Bar colours as {r,g,b} on/off flags, white first down to black.
    always_comb begin
        w_bar_on = 3'b000;
        case (r_s1_bar)
            3'd0:    w_bar_on = 3'b111;
            3'd1:    w_bar_on = 3'b110;
            3'd2:    w_bar_on = 3'b011;
            3'd3:    w_bar_on = 3'b010;
            3'd4:    w_bar_on = 3'b101;
            3'd5:    w_bar_on = 3'b100;
            3'd6:    w_bar_on = 3'b001;
            default: w_bar_on = 3'b000;
        endcase
    end

    assign w_ramp = DATA_W'(r_s1_x[7:0]) << (DATA_W - 8);

    always_comb begin
        w_rgb = '0;
        if (r_s1_de) begin
            case (r_mode_l)
                2'd0: w_rgb = {w_bar_on[2] ? c_ones : c_zero,
                               w_bar_on[1] ? c_ones : c_zero,
                               w_bar_on[0] ? c_ones : c_zero};
                2'd1: w_rgb = {w_ramp, w_ramp, w_ramp};
                2'd2: w_rgb = (r_s1_x[CHK_SHIFT] ^ r_s1_y_bit) ? {c_ones, c_ones, c_ones} : '0;
                default: w_rgb = r_solid_l;
            endcase
        end
    end

    always_ff @(posedge dp_clk or negedge rst_n) begin
        if (!rst_n) begin
            out_hs  <= 1'b0;
            out_vs  <= 1'b0;
            out_de  <= 1'b0;
            out_rgb <= '0;
        end else begin
            out_hs  <= r_s1_hs;
            out_vs  <= r_s1_vs;
            out_de  <= r_s1_de;
            out_rgb <= w_rgb;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vout_test_pattern.sv
`default_nettype none
// ============================================================================
// Module   : tb_vout_test_pattern
// Brief    : Randomized scoreboard bench for vout_test_pattern.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vout_test_pattern;

    localparam int DW = 10;
    localparam int CS = 5;

    logic            dp_clk;
    logic            rst_n;
    logic [11:0]     h_active;
    logic [1:0]      mode;
    logic [3*DW-1:0] solid_rgb;
    logic            in_hs, in_vs, in_de;
    logic            out_hs, out_vs, out_de;
    logic [3*DW-1:0] out_rgb;

    vout_test_pattern #(.DATA_W(DW), .CHK_SHIFT(CS)) dut (
        .dp_clk(dp_clk), .rst_n(rst_n), .h_active(h_active), .mode(mode),
        .solid_rgb(solid_rgb), .in_hs(in_hs), .in_vs(in_vs), .in_de(in_de),
        .out_hs(out_hs), .out_vs(out_vs), .out_de(out_de), .out_rgb(out_rgb)
    );

    typedef struct { int cyc; logic hs; logic vs; logic de; logic [3*DW-1:0] rgb; } exp_t;
    typedef struct { int cyc; logic [3*DW-1:0] rgb; } dir_t;

    exp_t sb[$];
    dir_t dq[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int test_id  = 0;

    // Reference model state: what the block should have latched at frame start
    int              m_mode;
    logic [3*DW-1:0] m_solid;
    int              m_bw;
    logic            m_prev_vs;

    initial begin
        dp_clk = 1'b0;
        forever #5 dp_clk = ~dp_clk;
    end

    always @(posedge dp_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
        end
    endtask

    function automatic logic [3*DW-1:0] ref_pix(input int md, input logic [3*DW-1:0] sol,
                                                input int bw, input int x, input int y);
        logic [DW-1:0] f, z, lv;
        int idx;
        logic [2:0] on;
        f = '1;
        z = '0;
        case (md)
            0: begin
                idx = (bw == 0) ? 0 : x / bw;
                if (idx > 7) idx = 7;
                case (idx)
                    0: on = 3'b111;  1: on = 3'b110;  2: on = 3'b011;  3: on = 3'b010;
                    4: on = 3'b101;  5: on = 3'b100;  6: on = 3'b001;  default: on = 3'b000;
                endcase
                return {on[2] ? f : z, on[1] ? f : z, on[0] ? f : z};
            end
            1: begin
                lv = DW'((x % 256) * (1 << (DW - 8)));
                return {lv, lv, lv};
            end
            2: return ((((x >> CS) ^ (y >> CS)) & 1) != 0) ? {f, f, f} : {z, z, z};
            default: return sol;
        endcase
    endfunction

    // Hand-derived spot values for specific pixels of the directed frames.
    function automatic void dir_expect(input int tid, input int x, input int y,
                                       output bit hit, output logic [3*DW-1:0] v);
        logic [3*DW-1:0] w;
        w   = {3{10'h3FF}};
        hit = 1'b1;
        v   = '0;
        if (tid == 1 && y == 0 && (x == 0 || x == 159))        v = w;
        else if (tid == 1 && y == 0 && x == 160)               v = {10'h3FF, 10'h3FF, 10'h000};
        else if (tid == 1 && y == 0 && x == 1279)              v = '0;
        else if (tid == 2 && y == 0 && x == 1119)              v = {10'h000, 10'h000, 10'h3FF};
        else if (tid == 2 && y == 0 && (x == 1120 || x == 1283)) v = '0;
        else if (tid == 3 && ((x == 0 && y == 0) || (x == 31 && y == 0) || (x == 32 && y == 32))) v = '0;
        else if (tid == 3 && ((x == 32 && y == 0) || (x == 0 && y == 32))) v = w;
        else if (tid == 4 && y == 0 && x == 5)                 v = {3{10'h014}};
        else if (tid == 4 && y == 0 && x == 255)               v = {3{10'h3FC}};
        else if (tid == 4 && y == 0 && x == 256)               v = '0;
        else if (tid == 5 && y == 2 && x == 0)                 v = w;
        else if (tid == 5 && y == 0 && x == 8)                 v = {10'h3FF, 10'h3FF, 10'h000};
        else if (tid == 6 && ((y == 0 && x == 0) || (y == 2 && x == 63))) v = 30'h123456;
        else if (tid == 8 && y == 0 && x == 0)                 v = w;
        else if (tid == 8 && y == 0 && x == 63)                v = '0;
        else hit = 1'b0;
    endfunction

    task automatic drive(input logic hs, input logic vs, input logic de, input int x, input int y);
        exp_t e;
        dir_t d;
        bit hit;
        logic [3*DW-1:0] v;
        in_hs = hs;
        in_vs = vs;
        in_de = de;
        if (vs && !m_prev_vs) begin
            m_mode  = int'(mode);
            m_solid = solid_rgb;
            m_bw    = int'(h_active) / 8;
        end
        m_prev_vs = vs;
        e.cyc = cyc + 2;
        e.hs  = hs;
        e.vs  = vs;
        e.de  = de;
        e.rgb = de ? ref_pix(m_mode, m_solid, m_bw, x, y) : '0;
        sb.push_back(e);
        if (de) begin
            dir_expect(test_id, x, y, hit, v);
            if (hit) begin
                d.cyc = cyc + 2;
                d.rgb = v;
                dq.push_back(d);
            end
        end
        @(posedge dp_clk);
        #1;
    endtask

    task automatic frame(input int hact, input int nl, input bit junk, input int chg_line,
                         input logic [1:0] chg_mode, input logic [3*DW-1:0] chg_solid);
        int htot;
        htot = hact + 12;
        for (int vl = 0; vl < 2; vl++) begin
            for (int c = 0; c < htot; c++) begin
                if (junk && vl == 0 && c == 1) begin
                    mode      = 2'($urandom);
                    solid_rgb = 30'($urandom);
                    h_active  = 12'($urandom);
                end
                drive(c >= 2 && c < 6, vl == 0, 1'b0, 0, 0);
            end
        end
        for (int l = 0; l < nl; l++) begin
            for (int c = 0; c < htot; c++) begin
                if (l == chg_line && c == 0) begin
                    mode      = chg_mode;
                    solid_rgb = chg_solid;
                    if (junk) h_active = 12'($urandom);
                end
                if (c < hact) drive(1'b0, 1'b0, 1'b1, c, l);
                else          drive((c - hact) >= 2 && (c - hact) < 6, 1'b0, 1'b0, 0, 0);
            end
        end
    endtask

    // Monitor: output is presented every cycle; compare whatever is due now.
    always @(negedge dp_clk) begin
        if (!rst_n) begin
            chk("rst_out", 64'({out_hs, out_vs, out_de, out_rgb}), 64'd0);
        end else begin
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                exp_t e;
                e = sb.pop_front();
                chk("pix", 64'({out_hs, out_vs, out_de, out_rgb}), 64'({e.hs, e.vs, e.de, e.rgb}));
            end
            while (dq.size() > 0 && dq[0].cyc <= cyc) begin
                dir_t d;
                d = dq.pop_front();
                chk("spot", 64'(out_rgb), 64'(d.rgb));
            end
        end
    end

    initial begin
        #3_000_000;
        failures++;
        $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int hact, nl;
        rst_n     = 1'b0;
        h_active  = 12'd0;
        mode      = 2'd0;
        solid_rgb = '0;
        in_hs     = 1'b0;
        in_vs     = 1'b0;
        in_de     = 1'b0;
        m_mode    = 0;
        m_solid   = '0;
        m_bw      = 0;
        m_prev_vs = 1'b0;
        repeat (3) @(posedge dp_clk);
        #1;
        rst_n = 1'b1;

        // 1280-wide bars: first frame warms up, second carries spot checks
        h_active = 12'd1280; mode = 2'd0;
        test_id = 0; frame(1280, 2, 1'b0, -1, 2'd0, '0);
        test_id = 1; frame(1280, 2, 1'b0, -1, 2'd0, '0);
        // Remainder absorbed by the last bar
        h_active = 12'd1284;
        test_id = 2; frame(1284, 1, 1'b0, -1, 2'd0, '0);
        // Checkerboard
        h_active = 12'd80; mode = 2'd2;
        test_id = 3; frame(80, 70, 1'b0, -1, 2'd2, '0);
        // Gray ramp wrapping at 256
        h_active = 12'd300; mode = 2'd1;
        test_id = 4; frame(300, 2, 1'b0, -1, 2'd1, '0);
        // Mid-frame switch to solid only takes effect next frame
        h_active = 12'd64; mode = 2'd0;
        test_id = 5; frame(64, 3, 1'b0, 1, 2'd3, 30'h123456);
        test_id = 6; frame(64, 3, 1'b0, -1, 2'd3, 30'h123456);

        // Randomized frames with mid-frame noise on the configuration inputs
        test_id = 0;
        for (int i = 0; i < 8; i++) begin
            hact      = (i == 0) ? 5 : int'($urandom_range(1, 200));
            nl        = int'($urandom_range(1, 6));
            h_active  = 12'(hact);
            mode      = 2'($urandom);
            solid_rgb = 30'($urandom);
            frame(hact, nl, 1'b1, int'($urandom_range(0, nl - 1)), 2'($urandom), 30'($urandom));
        end

        // Reset in the middle of an active line
        h_active = 12'd64; mode = 2'd0;
        for (int vl = 0; vl < 2; vl++)
            for (int c = 0; c < 76; c++) drive(c >= 2 && c < 6, vl == 0, 1'b0, 0, 0);
        for (int c = 0; c < 20; c++) drive(1'b0, 1'b0, 1'b1, c, 0);
        rst_n = 1'b0;
        in_hs = 1'b0;
        in_vs = 1'b0;
        in_de = 1'b0;
        #1;
        chk("async_rst", 64'({out_hs, out_vs, out_de, out_rgb}), 64'd0);
        sb.delete();
        dq.delete();
        m_mode    = 0;
        m_solid   = '0;
        m_bw      = 0;
        m_prev_vs = 1'b0;
        repeat (3) @(posedge dp_clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 30; c++) drive(1'b0, 1'b0, 1'b0, 0, 0);
        test_id = 8; frame(64, 2, 1'b0, -1, 2'd0, '0);
        test_id = 0;
        for (int c = 0; c < 4; c++) drive(1'b0, 1'b0, 1'b0, 0, 0);
        repeat (3) @(posedge dp_clk);
        #1;
        chk("drain", 64'(sb.size() + dq.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
